// File: rtl/bcd_edit_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_edit_ctrl_if
//   Bus between the front-panel controller and the 8-digit BCD counter.
//
//   Signals
//     en          controller -> counter   counter count enable
//     load        controller -> counter   write request
//     bitSW       controller -> counter   digit index being written
//     digitSW     controller -> counter   BCD value to write
//     numStorage  counter -> controller   live counter contents, 4 bits per digit
//
//   Handshake: load is the request (valid). Once raised, load stays high and
//   bitSW/digitSW stay stable until the addressed digit of numStorage reads
//   back equal to digitSW. That readback equality is the acknowledge (ready).
//   The controller also gives up after a bounded number of cycles. Because
//   the acknowledge is the readback itself, the counter can run from any
//   divided clock.
//
//   Modports
//     master  controller side
//     slave   counter side
// ---------------------------------------------------------------------------
interface bcd_edit_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = 3
);
  logic                    en;
  logic                    load;
  logic [IDX_W-1:0]        bitSW;
  logic [3:0]              digitSW;
  logic [4*NUM_DIGITS-1:0] numStorage;

  modport master (output en, output load, output bitSW, output digitSW,
                  input numStorage);
  modport slave  (input en, input load, input bitSW, input digitSW,
                  output numStorage);
endinterface

// File: rtl/bcd_edit_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_edit_ctrl
//   Front-panel controller for the 8-digit BCD counter.
//   RUN  : counter enable follows the run switch.
//   EDIT : a cursor selects a digit; inc/dec change its value and each change
//          is committed through a load handshake (WRITE state).
//
//   Ports
//     clk       board clock, rising edge
//     rst       asynchronous reset, active low
//     mode_btn  raw button, rising edge toggles RUN/EDIT
//     next_btn  raw button, rising edge advances the cursor
//     inc_btn   raw button, rising edge increments the selected digit
//     dec_btn   raw button, rising edge decrements the selected digit
//     run_sw    run switch (level)
//     cnt       counter bus (master side): en, load, bitSW, digitSW, numStorage
//     editing   1 whenever the controller is not in RUN
//     blink     cursor blink for the display, 0 outside EDIT
//     err       sticky write-timeout flag, cleared only by reset
//     state_dbg current FSM state
// ---------------------------------------------------------------------------
module bcd_edit_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT    = 2**20,
  parameter int BLINK_W    = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_btn,
  input  logic                  next_btn,
  input  logic                  inc_btn,
  input  logic                  dec_btn,
  input  logic                  run_sw,
  bcd_edit_ctrl_if.master       cnt,
  output logic                  editing,
  output logic                  blink,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_EDIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Button synchronisers: bit 3 mode, 2 next, 1 inc, 0 dec.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, sync3_q;
  logic [3:0] pulse;
  logic       mode_ev, next_ev, inc_ev, dec_ev;

  assign btn_raw = {mode_btn, next_btn, inc_btn, dec_btn};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~sync3_q;

  // Only the highest-priority edge of a cycle survives.
  assign mode_ev = pulse[3];
  assign next_ev = pulse[2] & ~pulse[3];
  assign inc_ev  = pulse[1] & ~(|pulse[3:2]);
  assign dec_ev  = pulse[0] & ~(|pulse[3:1]);

  function automatic logic [3:0] digit_at(input logic [4*NUM_DIGITS-1:0] word,
                                          input logic [IDX_W-1:0]        i);
    return word[4*i +: 4];
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, next_idx;
  logic [3:0]         val_q, val_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               en_q, en_d;
  logic               load_q, load_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      val_q   <= '0;
      timer_q <= '0;
      blink_q <= '0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      en_q    <= en_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    val_d    = val_q;
    timer_d  = timer_q;
    blink_d  = blink_q + 1'b1;
    en_d     = 1'b0;
    load_d   = 1'b0;
    err_d    = err_q;
    next_idx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    case (state_q)
      ST_RUN: begin
        en_d = run_sw;
        if (mode_ev) begin
          state_d = ST_EDIT;
          en_d    = 1'b0;
          idx_d   = '0;
          val_d   = digit_at(cnt.numStorage, IDX_W'(0));
          blink_d = '0;
        end
      end

      ST_EDIT: begin
        if (mode_ev) begin
          state_d = ST_RUN;
        end else if (next_ev) begin
          idx_d = next_idx;
          val_d = digit_at(cnt.numStorage, next_idx);
        end else if (inc_ev) begin
          // Non-BCD values (A-F) wrap to 0 like 9 does.
          val_d   = (val_q >= 4'd9) ? 4'd0 : val_q + 4'd1;
          timer_d = '0;
          load_d  = 1'b1;
          state_d = ST_WRITE;
        end else if (dec_ev) begin
          // Non-BCD values (A-F) collapse to 9 like 0 does.
          val_d   = (val_q == 4'd0 || val_q > 4'd9) ? 4'd9 : val_q - 4'd1;
          timer_d = '0;
          load_d  = 1'b1;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Button edges are ignored here; the write must finish first.
        load_d = 1'b1;
        if (digit_at(cnt.numStorage, idx_q) == val_q) begin
          load_d  = 1'b0;
          timer_d = '0;
          state_d = ST_EDIT;
        end else if (timer_q == TIMER_LAST) begin
          load_d  = 1'b0;
          timer_d = '0;
          err_d   = 1'b1;
          state_d = ST_EDIT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign cnt.en      = en_q;
  assign cnt.load    = load_q;
  assign cnt.bitSW   = idx_q;
  assign cnt.digitSW = val_q;
  assign editing     = (state_q != ST_RUN);
  assign blink       = (state_q == ST_EDIT) & blink_q[BLINK_W-1];
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule
